alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 28 ++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the arbitrated ALU: opcodes, FSM encoding,
// default widths.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREQ_DEF  = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Requester-ID width; never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath; all arithmetic wraps modulo 2^WIDTH.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (opcode)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_INC:  y = a + WIDTH'(1);
            OP_DEC:  y = a - WIDTH'(1);
            OP_PASS: y = a;
            OP_NOT:  y = ~a;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters;
// one operation in flight, IDLE -> EXEC -> RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int NREQ  = NREQ_DEF,
    localparam int IDW   = idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [3*NREQ-1:0]     req_opcode,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_y,
    output logic                  busy
);

    logic [1:0]       state;
    logic [IDW-1:0]   rr_ptr;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   id_q;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] alu_y;
    logic [IDW-1:0]   ptr_next;
    logic             accept;
    logic             rsp_done;

    // First requesting index at or above rr_ptr, wrapping to 0.
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!gnt_found && req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(j);
            end
        end
    end

    always_comb begin
        sel_op = req_opcode[3*int'(gnt_idx) +: 3];
        sel_a  = req_a[WIDTH*int'(gnt_idx) +: WIDTH];
        sel_b  = req_b[WIDTH*int'(gnt_idx) +: WIDTH];
    end

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && !rst && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept    = (state == ST_IDLE) && gnt_found;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_done  = rsp_valid && rsp_ready;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        ptr_next = rsp_id + IDW'(1);
        if (rsp_id == IDW'(NREQ - 1)) begin
            ptr_next = '0;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .opcode (op_q),
        .y      (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            rsp_y  <= '0;
            rsp_id <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= sel_op;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= gnt_idx;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_y  <= alu_y;
                    rsp_id <= id_q;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_done) begin
                        rr_ptr <= ptr_next;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table,
// multi-cycle corner sequences, randomized run against a model.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [3*N-1:0] req_opcode;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_y;
    logic           busy;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .WIDTH (W),
        .NREQ  (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .busy       (busy)
    );

    typedef struct {
        int         r;
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint unsigned m;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned r;
        m  = 64'h1_0000_0000;
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd0: r = (ua + ub) % m;
            3'd1: r = (ua + m - ub) % m;
            3'd2: r = (ua + 1) % m;
            3'd3: r = (ua + m - 1) % m;
            3'd4: r = ua;
            3'd5: r = m - 1 - ua;
            3'd6: r = ua | ub;
            default: r = ua & ub;
        endcase
        return r[W-1:0];
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        #1;
        chk("rst_hold_ready", req_ready, 0);
        tick();
        tick();
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic run_op(input logic [N-1:0] vm, input int r,
                          input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] y,
                          input string tag);
        logic [N-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        req_valid = vm;
        rsp_ready = 1'b1;
        req_opcode[3*r +: 3] = op;
        req_a[W*r +: W] = a;
        req_b[W*r +: W] = b;
        #1;
        chk({tag, ".idle_busy"}, busy, 0);
        chk({tag, ".ready"}, req_ready, oh);
        tick();
        req_valid = '0;
        req_opcode[3*r +: 3] = ~op;
        req_a[W*r +: W] = ~a;
        #1;
        chk({tag, ".exec_busy"}, busy, 1);
        chk({tag, ".exec_rv"}, rsp_valid, 0);
        chk({tag, ".exec_ready"}, req_ready, 0);
        tick();
        #1;
        chk({tag, ".rv"}, rsp_valid, 1);
        chk({tag, ".id"}, rsp_id, r);
        chk({tag, ".y"}, rsp_y, y);
        tick();
    endtask

    initial begin
        int ids[5];
        int cyc_at[5];
        int nrsp;
        int age;
        int ptr;
        int g;
        int exp_id;
        logic [W-1:0] exp_y;
        logic [N-1:0] exp_rdy;

        vt[0] = '{0, 3'd0, 32'd5,          32'd7,          32'd12};
        vt[1] = '{2, 3'd1, 32'd0,          32'd1,          32'hFFFFFFFF};
        vt[2] = '{2, 3'd2, 32'hFFFFFFFF,   32'd0,          32'd0};
        vt[3] = '{1, 3'd3, 32'd0,          32'd9,          32'hFFFFFFFF};
        vt[4] = '{3, 3'd4, 32'hDEADBEEF,   32'h1234,       32'hDEADBEEF};
        vt[5] = '{1, 3'd5, 32'd0,          32'd3,          32'hFFFFFFFF};
        vt[6] = '{0, 3'd6, 32'hF0F00000,   32'h00000F0F,   32'hF0F00F0F};
        vt[7] = '{3, 3'd7, 32'hFFFF00FF,   32'h0F0F0F0F,   32'h0F0F000F};
        vt[8] = '{2, 3'd0, 32'hFFFFFFFF,   32'd2,          32'd1};
        vt[9] = '{1, 3'd3, 32'h80000000,   32'd0,          32'h7FFFFFFF};

        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        do_reset();
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y", rsp_y, 0);
        chk("rst_id", rsp_id, 0);

        for (int i = 0; i < 10; i++) begin
            vec_t v;
            logic [N-1:0] m;
            v = vt[i];
            m = '0;
            m[v.r] = 1'b1;
            run_op(m, v.r, v.op, v.a, v.b, v.y, $sformatf("vec%0d", i));
        end

        // Backpressure: result held while consumer stalls
        req_opcode[3 +: 3] = 3'd5;
        req_a[W +: W] = '0;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        chk("bp.ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            req_valid = '1;
            #1;
            chk("bp.rv", rsp_valid, 1);
            chk("bp.y", rsp_y, 32'hFFFFFFFF);
            chk("bp.id", rsp_id, 1);
            chk("bp.ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.done_rv", rsp_valid, 1);
        tick();
        #1;
        chk("bp.after_busy", busy, 0);
        chk("bp.next_grant", req_ready, 4'b0100);
        req_valid = '0;

        // Priority after serving the top requester wraps to 0
        do_reset();
        run_op(4'b1000, 3, 3'd0, 32'd1, 32'd2, 32'd3, "pri3");
        run_op(4'b1001, 0, 3'd0, 32'd4, 32'd4, 32'd8, "pri0");
        run_op(4'b1001, 3, 3'd6, 32'd1, 32'd2, 32'd3, "pri3b");

        // Reset during EXEC drops the operation
        run_op(4'b0100, 2, 3'd0, 32'd1, 32'd1, 32'd2, "pre_rst");
        req_valid = '1;
        #1;
        chk("mid.ready", req_ready, 4'b1000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid.rv", rsp_valid, 0);
        chk("mid.busy", busy, 0);
        chk("mid.ptr0", req_ready, 4'b0001);
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("mid.no_rsp", rsp_valid, 0);
        end

        // Round robin with all requesting
        do_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 30 && nrsp < 5; c++) begin
            #1;
            if (rsp_valid) begin
                ids[nrsp]    = int'(rsp_id);
                cyc_at[nrsp] = c;
                nrsp++;
            end
            tick();
        end
        chk("rr.count", nrsp, 5);
        for (int k = 0; k < nrsp; k++) begin
            chk($sformatf("rr.id%0d", k), ids[k], k % N);
            if (k > 0) chk($sformatf("rr.gap%0d", k), cyc_at[k] - cyc_at[k-1], 3);
        end
        req_valid = '0;

        // Randomized run against the reference model
        do_reset();
        age = -1;
        ptr = 0;
        exp_id = 0;
        exp_y = '0;
        for (int c = 0; c < 2000; c++) begin
            req_valid  = N'($urandom);
            req_opcode = 12'($urandom);
            for (int r = 0; r < N; r++) begin
                req_a[W*r +: W] = ($urandom % 8 == 0) ? '1 : $urandom;
                req_b[W*r +: W] = ($urandom % 8 == 0) ? '0 : $urandom;
            end
            rsp_ready = ($urandom % 4 != 0);
            rst = ($urandom % 64 == 0);
            #1;
            g = pick(req_valid, ptr);
            exp_rdy = '0;
            if (age < 0 && !rst && g >= 0) exp_rdy[g] = 1'b1;
            chk("rnd.ready", req_ready, exp_rdy);
            chk("rnd.rv", rsp_valid, age == 1);
            chk("rnd.busy", busy, age >= 0);
            if (age == 1) begin
                chk("rnd.id", rsp_id, exp_id);
                chk("rnd.y", rsp_y, exp_y);
            end
            if (rst) begin
                age = -1;
                ptr = 0;
            end else if (age < 0) begin
                if (g >= 0) begin
                    exp_id = g;
                    exp_y  = ref_alu(req_opcode[3*g +: 3],
                                     req_a[W*g +: W], req_b[W*g +: W]);
                    age = 0;
                end
            end else if (age == 0) begin
                age = 1;
            end else if (rsp_ready) begin
                age = -1;
                ptr = (exp_id + 1) % N;
            end
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
